alu_issue_stage: RTL

- Decode-to-execute stage directly upstream of the ALU.
- Takes a fetched RV32I instruction, its PC and the register-file read data.
- Decodes ALU control, selects and forms the operands, and presents {a, b, alu_op} to the ALU through a registered valid/ready interface.
- A two-entry skid buffer breaks the ready path, so the ALU side can stall without a combinational in_ready dependency.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_decode.sv | 91 +++++++++
 rtl/alu_issue_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, RV32I opcode constants and the issue entry
// handed from the issue stage to the ALU.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         alu_op;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder: forms operands and ALU op from the
// instruction, PC and register read data. Unsupported encodings become a zero ADD.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output issue_entry_t    entry_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            base_f7;
  logic            alt_f7;
  logic            is_shift;
  logic            legal;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  alu_op_e         op;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign rd       = instr_i[11:7];
  assign base_f7  = (funct7 == FUNCT7_BASE);
  assign alt_f7   = (funct7 == FUNCT7_ALT);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // alt selects SUB for funct3=000 and SRA for funct3=101; ignored elsewhere.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_op = ALU_SLL;
      3'b010:  f3_to_op = ALU_SLT;
      3'b011:  f3_to_op = ALU_SLTU;
      3'b100:  f3_to_op = ALU_XOR;
      3'b101:  f3_to_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_op = ALU_OR;
      default: f3_to_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    legal = 1'b0;
    a     = '0;
    b     = '0;
    op    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        legal = base_f7 || (alt_f7 && (funct3 == 3'b000 || funct3 == 3'b101));
        a     = rs1_data_i;
        b     = is_shift ? {{(XLEN-5){1'b0}}, rs2_data_i[4:0]} : rs2_data_i;
        op    = f3_to_op(funct3, alt_f7);
      end
      OPC_OP_IMM: begin
        legal = !is_shift || base_f7 || (alt_f7 && funct3 == 3'b101);
        a     = rs1_data_i;
        b     = is_shift ? {{(XLEN-5){1'b0}}, instr_i[24:20]}
                         : {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        op    = f3_to_op(funct3, alt_f7 && funct3 == 3'b101);
      end
      OPC_LUI: begin
        legal = 1'b1;
        b     = {instr_i[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a     = pc_i;
        b     = {instr_i[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      a  = '0;
      b  = '0;
      op = ALU_ADD;
    end
  end

  assign entry_o.a         = a;
  assign entry_o.b         = b;
  assign entry_o.alu_op    = op;
  assign entry_o.rd        = rd;
  assign entry_o.reg_write = legal && (rd != 5'd0);
  assign entry_o.illegal   = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes into an issue entry and hands it to the
// ALU through a two-entry skid buffer so in_ready never depends on out_ready.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [OP_W-1:0] out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holding valid keeps its payload stable until that edge.
  buf_state_e   state_q, state_d;
  issue_entry_t m_q, m_d;
  issue_entry_t s_q, s_d;
  issue_entry_t dec_entry;
  logic         in_ready_q, in_ready_d;
  logic         in_fire;
  logic         out_fire;

  alu_decode u_decode (
    .instr_i    (in_instr),
    .pc_i       (in_pc),
    .rs1_data_i (in_rs1_data),
    .rs2_data_i (in_rs2_data),
    .entry_o    (dec_entry)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_fire) begin
          m_d     = dec_entry;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_fire && !out_fire) begin
          s_d     = dec_entry;
          state_d = BUF_FULL;
        end else if (!in_fire && out_fire) begin
          state_d = BUF_EMPTY;
        end else if (in_fire && out_fire) begin
          m_d = dec_entry;
        end
      end
      BUF_FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    // Flush wins: any entry captured this cycle is abandoned along with M and S.
    if (flush) begin
      state_d = BUF_EMPTY;
    end
    in_ready_d = (state_d != BUF_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign out_a         = m_q.a;
  assign out_b         = m_q.b;
  assign out_alu_op    = m_q.alu_op;
  assign out_rd        = m_q.rd;
  assign out_reg_write = m_q.reg_write;
  assign out_illegal   = m_q.illegal;

endmodule
